// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM arbiter: FSM encoding, default timing
// parameters and the byte-lane decode used for CPU writes.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        CPU_WR = 2'd2,
        VID_RD = 2'd3
    } state_t;

    localparam int WAIT_DEF  = 1;
    localparam int BURST_DEF = 8;

    // Byte access drives only the lane picked by adr[1:0]; word access drives all four.
    function automatic logic [3:0] lane_be_n(input logic [1:0] adr, input logic ben);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << adr;
        return ben ? ~one_hot : 4'h0;
    endfunction

endpackage

// File: rtl/sram_cycle.sv
// One SRAM access of WAIT+1 cycles: wait counter, strobe generation and the
// done flag marking the final cycle. Restarts at wcnt=0 after every access.
module sram_cycle #(
    parameter int WAIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic active,
    input  logic wr,
    output logic done,
    output logic oe_n,
    output logic we_n,
    output logic drive
);

    logic [2:0] wcnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt <= 3'd0;
        end else if (enable) begin
            if (!active || done) wcnt <= 3'd0;
            else                 wcnt <= wcnt + 3'd1;
        end
    end

    assign done  = active && (wcnt == 3'(WAIT));
    assign oe_n  = !(active && !wr);
    // Write strobe releases one cycle early so data is held past the rising we_n.
    assign we_n  = !(active && wr && (wcnt < 3'(WAIT)));
    assign drive = active && wr;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between the RISC5 CPU port and the video
// burst reader, with fixed priority: urgent video, pending CPU, then video.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT  = WAIT_DEF,
    parameter int BURST = BURST_DEF,
    parameter int AW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [23:0]   cpu_adr,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic          cpu_ben,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          stallX,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    input  logic          vid_urgent,
    output logic          vid_ack,
    output logic [31:0]   vid_rdata,
    output logic [AW-1:0] sram_adr,
    input  logic [31:0]   sram_din,
    output logic [31:0]   sram_dout,
    output logic          sram_drive,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic [3:0]    sram_be_n,
    output logic [1:0]    state_dbg
);

    // Handshakes: a CPU request is taken in any enabled cycle with stallX=0, after
    // which stallX stays high until the access is finished; vid_ack is a one-clock
    // pulse qualifying vid_rdata, one per burst word, with no back-pressure.
    state_t        state, state_next, arb_state;
    logic          pend, pend_wr, pend_ben;
    logic [AW+1:0] pend_adr;
    logic [31:0]   pend_wdata;
    logic [AW-1:0] vaddr;
    logic [4:0]    bcnt;
    logic          done, cap, cpu_served, cpu_any, cpu_op_wr;
    logic          last_word, arb_point, vid_word_done;
    logic          adr_unused;

    assign adr_unused = ^cpu_adr[23:AW+2];

    sram_cycle #(.WAIT(WAIT)) u_cycle (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .active (state != IDLE),
        .wr     (state == CPU_WR),
        .done   (done),
        .oe_n   (sram_oe_n),
        .we_n   (sram_we_n),
        .drive  (sram_drive)
    );

    assign stallX        = pend;
    assign sram_dout     = pend_wdata;
    assign state_dbg     = state;
    assign cap           = !pend && (cpu_rd || cpu_wr);
    assign cpu_served    = ((state == CPU_RD) || (state == CPU_WR)) && done;
    assign cpu_any       = (pend && !cpu_served) || cap;
    assign cpu_op_wr     = (pend && !cpu_served) ? pend_wr : cpu_wr;
    assign last_word     = (bcnt == 5'(BURST - 1));
    assign vid_word_done = (state == VID_RD) && done;
    assign arb_point     = (state == IDLE) || (done && ((state != VID_RD) || last_word));

    always_comb begin
        arb_state  = IDLE;
        state_next = state;
        sram_adr   = '0;
        sram_be_n  = 4'hF;
        if (vid_req && vid_urgent) arb_state = VID_RD;
        else if (cpu_any)          arb_state = cpu_op_wr ? CPU_WR : CPU_RD;
        else if (vid_req)          arb_state = VID_RD;
        if (arb_point) state_next = arb_state;
        case (state)
            CPU_RD: begin
                sram_adr  = pend_adr[AW+1:2];
                sram_be_n = 4'h0;
            end
            CPU_WR: begin
                sram_adr  = pend_adr[AW+1:2];
                sram_be_n = lane_be_n(pend_adr[1:0], pend_ben);
            end
            VID_RD: begin
                sram_adr  = vaddr;
                sram_be_n = 4'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pend       <= 1'b0;
            pend_wr    <= 1'b0;
            pend_ben   <= 1'b0;
            pend_adr   <= '0;
            pend_wdata <= '0;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
            vid_ack    <= 1'b0;
            vaddr      <= '0;
            bcnt       <= '0;
        end else begin
            // Pulse lasts exactly one clock even if enable drops right after it.
            vid_ack <= enable && vid_word_done;
            if (enable) begin
                state <= state_next;
                if (cap) begin
                    pend       <= 1'b1;
                    pend_wr    <= cpu_wr;
                    pend_ben   <= cpu_ben;
                    pend_adr   <= cpu_adr[AW+1:0];
                    pend_wdata <= cpu_wdata;
                end else if (cpu_served) begin
                    pend <= 1'b0;
                end
                if ((state == CPU_RD) && done) cpu_rdata <= sram_din;
                if (vid_word_done) begin
                    vid_rdata <= sram_din;
                    vaddr     <= vaddr + AW'(1);
                    bcnt      <= bcnt + 5'd1;
                end
                if (arb_point && (arb_state == VID_RD)) begin
                    vaddr <= vid_adr;
                    bcnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model, expected queues for CPU
// reads and video words, and a negedge monitor that pops and compares.
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst, enable;
    logic [23:0]   cpu_adr;
    logic          cpu_rd, cpu_wr, cpu_ben;
    logic [31:0]   cpu_wdata, cpu_rdata;
    logic          stallX;
    logic          vid_req, vid_urgent, vid_ack;
    logic [AW-1:0] vid_adr, sram_adr;
    logic [31:0]   vid_rdata, sram_din, sram_dout;
    logic          sram_drive, sram_oe_n, sram_we_n;
    logic [3:0]    sram_be_n;
    logic [1:0]    state_dbg;

    logic [31:0]   mem [0:(1<<AW)-1];
    bit            mem_valid [0:(1<<AW)-1];

    logic [31:0]   cpu_exp_q[$];
    logic [31:0]   vid_exp_q[$];
    logic          op_q[$];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, ack_count = 0, last_ack_cyc = 0, spacing_err = 0;
    int m_stall, m_oe, m_we, m_drv;
    logic [3:0] m_be;
    logic [7:0] m_we_pat;
    logic prev_stall = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.WAIT(1), .BURST(8), .AW(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_ben(cpu_ben),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stallX(stallX),
        .vid_req(vid_req), .vid_adr(vid_adr), .vid_urgent(vid_urgent),
        .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .sram_adr(sram_adr), .sram_din(sram_din), .sram_dout(sram_dout),
        .sram_drive(sram_drive), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n), .state_dbg(state_dbg)
    );

    // Power-up SRAM contents: word 0x40 holds 0xDEADBEEF, every other word is {adr, 14'h1ACE}.
    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return (a == 18'h00040) ? 32'hDEADBEEF : {a, 14'h1ACE};
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return mem_valid[a] ? mem[a] : init_word(a);
    endfunction

    always_comb sram_din = mem_valid[sram_adr] ? mem[sram_adr] : init_word(sram_adr);

    always @(posedge clk) begin
        if (!sram_we_n && sram_drive) begin
            logic [31:0] w;
            w = mem_word(sram_adr);
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) w[8*b +: 8] = sram_dout[8*b +: 8];
            mem[sram_adr]       <= w;
            mem_valid[sram_adr] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (vid_ack) begin
                check("vid_ack_expected", 32'(vid_exp_q.size() != 0), 1);
                if (vid_exp_q.size() != 0) check("vid_rdata", vid_rdata, vid_exp_q.pop_front());
                if (ack_count > 0 && (cyc - last_ack_cyc) != 2) spacing_err++;
                last_ack_cyc = cyc;
                ack_count++;
            end
            if (prev_stall && !stallX) begin
                check("cpu_done_expected", 32'(op_q.size() != 0), 1);
                if (op_q.size() != 0 && !op_q.pop_front())
                    check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
            end
        end
        prev_stall = stallX;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_issue(input logic wr, input logic [23:0] adr, input logic ben,
                             input logic [31:0] wdata, input logic [31:0] exp_rd);
        check("capture_stallx", stallX, 0);
        cpu_adr = adr; cpu_rd = !wr; cpu_wr = wr; cpu_ben = ben; cpu_wdata = wdata;
        op_q.push_back(wr);
        if (!wr) cpu_exp_q.push_back(exp_rd);
        tick();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic measure();
        bit fin = 1'b0;
        m_stall = 0; m_oe = 0; m_we = 0; m_drv = 0; m_be = 4'hF; m_we_pat = '0;
        for (int i = 0; i < 300 && !fin; i++) begin
            @(negedge clk); #1;
            if (!stallX) fin = 1'b1;
            else begin
                if (!sram_oe_n) m_oe++;
                if (!sram_we_n) m_we++;
                if (sram_drive) begin m_drv++; m_be = sram_be_n; end
                if (m_stall < 8) m_we_pat[m_stall] = sram_we_n;
                m_stall++;
            end
        end
        check("stall_timeout", 32'(fin), 1);
    endtask

    task automatic push_burst(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            vid_exp_q.push_back(init_word(a));
        end
        ack_count = 0; spacing_err = 0;
    endtask

    task automatic wait_vid(input int n_acks);
        bit fin = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            @(negedge clk); #1;
            if (vid_exp_q.size() == 0 && ack_count >= n_acks) fin = 1'b1;
        end
        check("vid_timeout", 32'(fin), 1);
        check("vid_ack_count", ack_count, n_acks);
        check("vid_ack_spacing", spacing_err, 0);
        repeat (2) tick();
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; cpu_adr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_ben = 1'b0; cpu_wdata = '0; vid_req = 1'b0; vid_adr = '0; vid_urgent = 1'b0;
        repeat (3) tick();
        check("rst_stallx", stallX, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_be_n", sram_be_n, 4'hF);
        check("rst_drive", sram_drive, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_sram_adr", sram_adr, 0);
        check("rst_state", state_dbg, 2'(IDLE));
        rst = 1'b1;
        tick();

        // Plain read on an idle bus
        cpu_issue(1'b0, 24'h000100, 1'b0, 32'h0, 32'hDEADBEEF);
        measure();
        check("rd_stall_cycles", m_stall, 2);
        check("rd_oe_cycles", m_oe, 2);
        check("rd_we_cycles", m_we, 0);
        repeat (2) tick();

        // Byte writes to lanes 3 and 1, a full-word write, then readbacks
        cpu_issue(1'b1, 24'h000103, 1'b1, 32'h5A5A5A5A, 32'h0);
        measure();
        check("wr_stall_cycles", m_stall, 2);
        check("wr_we_cycles", m_we, 1);
        check("wr_we_pattern", m_we_pat[1:0], 2'b10);
        check("wr_drive_cycles", m_drv, 2);
        check("wr_oe_cycles", m_oe, 0);
        check("wr_be_lane3", m_be, 4'b0111);
        check("wr_mem_lane3", mem_word(18'h00040), 32'h5AADBEEF);
        cpu_issue(1'b1, 24'h000101, 1'b1, 32'h77777777, 32'h0);
        measure();
        check("wr_be_lane1", m_be, 4'b1101);
        check("wr_mem_lane1", mem_word(18'h00040), 32'h5AAD77EF);
        cpu_issue(1'b1, 24'h000500, 1'b0, 32'h12345678, 32'h0);
        measure();
        check("wr_be_word", m_be, 4'b0000);
        cpu_issue(1'b0, 24'h000100, 1'b0, 32'h0, 32'h5AAD77EF);
        measure();
        cpu_issue(1'b0, 24'h000500, 1'b0, 32'h0, 32'h12345678);
        measure();
        repeat (2) tick();

        // Non-urgent video and CPU capture together: CPU wins
        vid_adr = 18'h01000; vid_req = 1'b1;
        push_burst(18'h01000, 8);
        cpu_issue(1'b0, 24'h000200, 1'b0, 32'h0, 32'h00201ACE);
        measure();
        vid_req = 1'b0;
        check("cpu_first_stall", m_stall, 2);
        check("cpu_first_no_ack", ack_count, 0);
        wait_vid(8);

        // CPU read arriving mid-burst waits for the whole burst
        vid_adr = 18'h02000; push_burst(18'h02000, 8);
        vid_req = 1'b1; tick(); vid_req = 1'b0;
        repeat (3) tick();
        cpu_issue(1'b0, 24'h000300, 1'b0, 32'h0, 32'h00301ACE);
        measure();
        check("midburst_stall", m_stall, 14);
        check("midburst_acks_first", ack_count, 8);
        wait_vid(8);

        // Urgent video beats a simultaneous CPU capture
        vid_adr = 18'h05000; push_burst(18'h05000, 8);
        vid_req = 1'b1; vid_urgent = 1'b1;
        cpu_issue(1'b0, 24'h000600, 1'b0, 32'h0, 32'h00601ACE);
        vid_req = 1'b0; vid_urgent = 1'b0;
        measure();
        check("urgent_stall", m_stall, 18);
        check("urgent_acks_first", ack_count, 8);
        wait_vid(8);

        // Burst wrapping past the top of SRAM
        vid_adr = 18'h3FFFE; push_burst(18'h3FFFE, 8);
        vid_req = 1'b1; tick(); vid_req = 1'b0;
        wait_vid(8);

        // Reset in the middle of a burst after three words
        vid_adr = 18'h04000; push_burst(18'h04000, 3);
        vid_req = 1'b1; tick(); vid_req = 1'b0;
        for (int i = 0; i < 100 && ack_count < 3; i++) begin
            @(negedge clk); #1;
        end
        check("rst_burst_acks_before", ack_count, 3);
        rst = 1'b0;
        tick();
        check("midrst_state", state_dbg, 2'(IDLE));
        check("midrst_stallx", stallX, 0);
        check("midrst_oe_n", sram_oe_n, 1);
        check("midrst_we_n", sram_we_n, 1);
        check("midrst_be_n", sram_be_n, 4'hF);
        check("midrst_cpu_rdata", cpu_rdata, 0);
        rst = 1'b1;
        repeat (20) tick();
        check("midrst_no_more_acks", ack_count, 3);

        // Clock enable low for 5 cycles in the first wait cycle of a read
        cpu_issue(1'b0, 24'h000400, 1'b0, 32'h0, 32'h00401ACE);
        enable = 1'b0;
        fork
            begin
                repeat (5) tick();
                enable = 1'b1;
            end
        join_none
        measure();
        check("enable_stall", m_stall, 7);
        check("enable_oe_cycles", m_oe, 7);
        repeat (3) tick();

        check("end_cpu_queue", cpu_exp_q.size() + op_q.size(), 0);
        check("end_vid_queue", vid_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 32-bit asynchronous SRAM between the RISC5 CPU data/instruction port and the video refresh reader.
- Drives stallX back to the CPU while a CPU access is waiting or in progress.
- Sequences SRAM strobes with a programmable wait-state count.
- Sits at top level between RISC5 and the SRAM pins; the video controller attaches as a burst-read requester.

Parameters:
- WAIT, 1: extra SRAM cycles per access; an access takes WAIT+1 cycles; legal range 1..7.
- BURST, 8: words read per video grant; power of two, 1..16.
- AW, 18: SRAM word-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low
- enable  in  1  clock enable; all state frozen when low
- cpu_adr  in  24  CPU byte address
- cpu_rd  in  1  CPU read request, unmasked by stallX
- cpu_wr  in  1  CPU write request, unmasked by stallX
- cpu_ben  in  1  byte access
- cpu_wdata  in  32  CPU write data, byte lanes already replicated
- cpu_rdata  out  32  read data to CPU inbus
- stallX  out  1  CPU stall
- vid_req  in  1  video burst request, level
- vid_adr  in  AW  video burst start word address
- vid_urgent  in  1  video FIFO below threshold
- vid_ack  out  1  one-cycle pulse per delivered video word
- vid_rdata  out  32  video word, valid with vid_ack
- sram_adr  out  AW  SRAM word address
- sram_din  in  32  SRAM read data
- sram_dout  out  32  SRAM write data
- sram_drive  out  1  data-bus output enable
- sram_oe_n  out  1  SRAM output enable
- sram_we_n  out  1  SRAM write enable
- sram_be_n  out  4  SRAM byte lanes

Behaviour:
- Reset (rst=0 at a clk edge with enable=1):
  - state IDLE; CPU pending request and video burst cleared, no further vid_ack.
  - stallX=0, vid_ack=0, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_drive=0, cpu_rdata=0, sram_adr=0.
- States: IDLE, CPU_RD, CPU_WR, VID_RD. The wait counter wcnt counts 0..WAIT inside every access state.
- CPU capture:
  - cpu_rd or cpu_wr is sampled in any cycle with stallX=0.
  - On sampling, address, wdata, ben and op are latched into the pending register.
  - cpu_rd and cpu_wr both high is illegal; treat as write.
- stallX:
  - High in every cycle after the capture cycle until the access completes.
  - Falls in the cycle in which cpu_rdata holds the new word (reads) or the write has finished.
  - cpu_rdata holds its value until the next CPU read completes.
- Arbitration, evaluated in IDLE and at the end of every access; no preemption mid-access or mid-burst:
  1. video if vid_req and vid_urgent;
  2. CPU pending;
  3. video if vid_req.
- A CPU request captured in the same cycle the arbiter is in IDLE goes directly to CPU_RD/CPU_WR on the next edge.
- A video request presented simultaneously with a CPU capture loses unless urgent.
- CPU_RD:
  - sram_adr=cpu_adr[AW+1:2]; oe_n=0 for all WAIT+1 cycles; be_n=0.
  - sram_din is registered into cpu_rdata at wcnt==WAIT.
  - Reads are always full word; the CPU selects the lane.
- CPU_WR:
  - sram_drive=1 for all cycles; we_n=0 for wcnt<WAIT; we_n=1 in the final cycle (data hold).
  - be_n: ben=0 gives 4'h0; ben=1 gives all high except bit cpu_adr[1:0].
- VID_RD:
  - Reads BURST consecutive words from the vid_adr latched at grant.
  - The address increments modulo 2^AW, so wrap at the top of SRAM is legal.
  - vid_ack pulses with vid_rdata in the cycle after each word's final wait cycle.
  - Returns to arbitration after word BURST-1.
  - vid_req dropping mid-burst does not shorten the burst.
- Worst-case CPU latency is BURST*(WAIT+1) + (WAIT+1) + 1 cycles.
- With enable=0: no state change; outputs hold; vid_ack is not re-pulsed.

Decomposition:
- Package sram_arb_pkg:
  - state enum;
  - WAIT/BURST defaults;
  - byte-lane decode function (adr[1:0], ben to be_n).
- Sub-module sram_cycle:
  - wait counter, strobe generation (oe_n, we_n, drive), done pulse;
  - reused by all access states.

Test Plan:
- WAIT=1, idle bus. CPU read of word 0x000100 (SRAM holds 0xDEADBEEF) -> stallX high for 2 cycles, cpu_rdata=0xDEADBEEF as stallX falls, oe_n low 2 cycles.
- CPU byte write, ben=1, adr=0x000103, wdata=0x5A5A5A5A -> be_n=4'b0111, we_n low 1 cycle then high 1 cycle, drive high 2 cycles, only byte 3 changed.
- vid_req (non-urgent) and CPU read captured in the same cycle -> CPU served first, then 8 vid_ack pulses at 2-cycle spacing, addresses vid_adr..vid_adr+7.
- During a video burst a CPU read arrives -> stallX held until the burst ends plus 3 cycles; no vid_ack is lost.
- vid_urgent=1 with CPU pending at end of a CPU access -> video granted first.
- vid_adr=0x3FFFE, BURST=8 -> addresses wrap to 0x00000..0x00005.
- rst low mid-burst after 3 acks -> next cycle IDLE, stallX=0, strobes high, no further vid_ack.
- enable low for 5 cycles mid-access -> wcnt and strobes frozen; completion delayed by exactly 5 cycles.
